hex_display_ctrl: RTL and testbench

Memory-mapped controller that owns the eight 7-segment outputs (hex0..hex7) of the IO subsystem. The LSU store path writes a 32-bit value plus a mode bit. The block renders the value as 8 hex nibbles (1 cycle) or as unsigned decimal, using a sequential double-dabble binary-to-BCD converter (one shift per cycle). It drives the registered, active-low segment buses that the top-level exposes as o_io_hex0..o_io_hex7.

---
 rtl/hex_disp_pkg.sv | 32 +++
 rtl/hex_seg_decoder.sv | 12 +
 rtl/hex_display_ctrl.sv | 115 +++++++++++
 tb/tb_hex_display_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the 7-segment display controller:
// FSM states, active-low segment codes and the double-dabble digit adjust.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry N is the glyph for nibble N.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Add 3 to every BCD digit >= 5 so the following left shift carries correctly.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low 7-segment decoder with a blank override.
module hex_seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Eight-digit 7-segment controller: shows a written word as hex (one cycle)
// or unsigned decimal via a one-shift-per-cycle double-dabble converter.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int BLANK_LZ  = 1,
  parameter int CONV_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic        i_mode,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovf,
  output logic [6:0]  o_hex0,
  output logic [6:0]  o_hex1,
  output logic [6:0]  o_hex2,
  output logic [6:0]  o_hex3,
  output logic [6:0]  o_hex4,
  output logic [6:0]  o_hex5,
  output logic [6:0]  o_hex6,
  output logic [6:0]  o_hex7,
  output state_t      o_state
);

  localparam int CNT_W = $clog2(CONV_BITS + 1);

  state_t               state_q;
  logic                 mode_q;
  logic [31:0]          data_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [CONV_BITS-1:0] bin_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 done_q;
  logic                 ovf_q;
  logic [6:0]           seg_q [8];
  logic [6:0]           seg_d [8];
  logic [BCD_W-1:0]     bcd_adj;

  assign bcd_adj = bcd_adjust(bcd_q);

  // A digit is blank in decimal mode when it and every digit above it are zero.
  for (genvar n = 0; n < 8; n++) begin : g_digit
    logic [3:0] nib;
    logic       blank;
    assign nib = mode_q ? bcd_q[4*n +: 4] : data_q[4*n +: 4];
    if (n == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = mode_q && (BLANK_LZ != 0) && (bcd_q[BCD_W-1:4*n] == '0);
    end
    hex_seg_decoder u_dec (
      .nibble (nib),
      .blank  (blank),
      .seg    (seg_d[n])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      data_q  <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 8; i++) seg_q[i] <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_wr_en) begin
            mode_q  <= i_mode;
            data_q  <= i_wr_data;
            bcd_q   <= '0;
            bin_q   <= i_wr_data[CONV_BITS-1:0];
            cnt_q   <= '0;
            state_q <= i_mode ? ST_SHIFT : ST_UPDATE;
          end
        end
        ST_SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[CONV_BITS-1]};
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CONV_BITS - 1)) state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) seg_q[i] <= seg_d[i];
          ovf_q   <= mode_q && (bcd_q[BCD_W-1:32] != '0);
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;
  assign o_ovf   = ovf_q;
  assign o_state = state_q;
  assign o_hex0  = seg_q[0];
  assign o_hex1  = seg_q[1];
  assign o_hex2  = seg_q[2];
  assign o_hex3  = seg_q[3];
  assign o_hex4  = seg_q[4];
  assign o_hex5  = seg_q[5];
  assign o_hex6  = seg_q[6];
  assign o_hex7  = seg_q[7];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed vector table, hand-written corner
// sequences, and random writes checked against an arithmetic reference model.
module tb_hex_display_ctrl;
  import hex_disp_pkg::*;

  logic        clk;
  logic        i_reset;
  logic        i_wr_en;
  logic [31:0] i_wr_data;
  logic        i_mode;
  logic        o_busy, o_done, o_ovf;
  logic [6:0]  o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_hex6, o_hex7;
  state_t      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_ctrl #(.BLANK_LZ(1), .CONV_BITS(32)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_wr_en   (i_wr_en),
    .i_wr_data (i_wr_data),
    .i_mode    (i_mode),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_ovf     (o_ovf),
    .o_hex0    (o_hex0),
    .o_hex1    (o_hex1),
    .o_hex2    (o_hex2),
    .o_hex3    (o_hex3),
    .o_hex4    (o_hex4),
    .o_hex5    (o_hex5),
    .o_hex6    (o_hex6),
    .o_hex7    (o_hex7),
    .o_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [55:0] all_segs();
    return {o_hex7, o_hex6, o_hex5, o_hex4, o_hex3, o_hex2, o_hex1, o_hex0};
  endfunction

  // Reference model: digits from division, blanking from magnitude.
  function automatic logic [55:0] model_segs(input logic mode, input logic [31:0] data);
    logic [55:0] r;
    longint unsigned v, p, d;
    v = longint'(data);
    p = 1;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (mode) begin
        d = (v / p) % 10;
        r[k*7 +: 7] = (k > 0 && v < p) ? 7'h7F : seg_ref[int'(d)];
        p = p * 10;
      end else begin
        r[k*7 +: 7] = seg_ref[int'((data >> (4*k)) & 32'hF)];
      end
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic mode, input logic [31:0] data);
    return mode && (longint'(data) > 64'd99999999);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Driver: one write, then wait (bounded) for o_done and check the result.
  task automatic run_write(input logic mode, input logic [31:0] data,
                           input logic [55:0] exp_segs, input logic exp_ovf,
                           input bit tail, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = data; i_mode = mode;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    check({tag, " busy_after_e0"}, 64'(o_busy), 64'(1));
    lat = 0; seen = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(posedge clk); #1;
      if (o_done) begin seen = 1; lat = c; end
    end
    check({tag, " latency"}, 64'(lat), 64'(mode ? 33 : 1));
    check({tag, " segs"}, 64'(all_segs()), 64'(exp_segs));
    check({tag, " ovf"}, 64'(o_ovf), 64'(exp_ovf));
    check({tag, " busy_at_done"}, 64'(o_busy), 64'(0));
    if (tail) begin
      @(posedge clk); #1;
      check({tag, " done_single"}, 64'(o_done), 64'(0));
    end
  endtask

  typedef struct packed {
    logic        mode;
    logic [31:0] data;
    logic [55:0] segs;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dones, lat;
    logic m;
    logic [31:0] d;

    vecs[0] = '{1'b0, 32'hDEADBEEF, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0};
    vecs[1] = '{1'b1, 32'd12345678, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0};
    vecs[2] = '{1'b1, 32'd305,      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}, 1'b0};
    vecs[3] = '{1'b1, 32'd0,        {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}, 1'b1};
    vecs[5] = '{1'b1, 32'd777,      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h78, 7'h78}, 1'b0};

    i_reset = 1'b1; i_wr_en = 1'b0; i_wr_data = '0; i_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset segs", 64'(all_segs()), {8'h0, {8{7'h7F}}});
    check("reset busy", 64'(o_busy), 64'(0));
    check("reset done", 64'(o_done), 64'(0));
    check("reset ovf",  64'(o_ovf),  64'(0));
    @(negedge clk); i_reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_write(vecs[i].mode, vecs[i].data, vecs[i].segs, vecs[i].ovf, 1'b1, $sformatf("vec%0d", i));

    // Write accepted on the edge where o_done is still high.
    run_write(1'b0, 32'h00000ABC, model_segs(1'b0, 32'h00000ABC), 1'b0, 1'b0, "b2b_first");
    run_write(1'b1, 32'd42, model_segs(1'b1, 32'd42), 1'b0, 1'b1, "b2b_second");

    // Write of 0 five cycles into a decimal conversion of 777 must be dropped.
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 32'd777; i_mode = 1'b1;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    dones = 0; lat = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      i_wr_en = (c == 5); i_wr_data = 32'd0; i_mode = 1'b1;
      @(posedge clk); #1;
      if (o_done) begin dones++; if (lat == 0) lat = c; end
    end
    i_wr_en = 1'b0;
    check("busy_write done_count", 64'(dones), 64'(1));
    check("busy_write latency", 64'(lat), 64'(33));
    check("busy_write segs", 64'(all_segs()), 64'(model_segs(1'b1, 32'd777)));

    // Reset in the middle of a decimal conversion.
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 32'd12345678; i_mode = 1'b1;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (o_done) dones++;
    end
    @(negedge clk); i_reset = 1'b1;
    #1;
    check("midreset segs", 64'(all_segs()), {8'h0, {8{7'h7F}}});
    check("midreset busy", 64'(o_busy), 64'(0));
    check("midreset ovf",  64'(o_ovf),  64'(0));
    @(negedge clk); i_reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (o_done) dones++;
    end
    check("midreset no_done", 64'(dones), 64'(0));
    run_write(1'b0, 32'h1, {{7{7'h40}}, 7'h79}, 1'b0, 1'b1, "after_reset_hex1");

    // Random writes against the model.
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 99999)) : $urandom;
      run_write(m, d, model_segs(m, d), model_ovf(m, d), 1'b1, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
